locked_ckt_query_ctrl: RTL and testbench

//  Sequences access to one key-locked combinational benchmark netlist (32 PIs, 32 POs, 16 key bits).

---
 rtl/locked_ckt_query_ctrl.sv | 128 ++++++++++++
 tb/tb_locked_ckt_query_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/locked_ckt_query_ctrl.sv
// locked_ckt_query_ctrl: serial key load, one pattern per query into a locked netlist, settle, capture, return.
// Optional KEY_PARITY_EN: key load takes an extra even-parity bit and flags mismatches on key_err.
module locked_ckt_query_ctrl #(
    parameter int NUM_IN     = 32,
    parameter int NUM_OUT    = 32,
    parameter int KEY_W      = 16,
    parameter int SETTLE_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_sdata,
    input  logic               key_svalid,
    input  logic               key_clear,
    output logic               key_loaded,
    input  logic [NUM_IN-1:0]  pat_data,
    input  logic               pat_valid,
    output logic               pat_ready,
    output logic [NUM_IN-1:0]  ckt_in,
    output logic [KEY_W-1:0]   ckt_key,
    input  logic [NUM_OUT-1:0] ckt_out,
    output logic [NUM_OUT-1:0] resp_data,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [15:0]        query_cnt,
    output logic               key_err
);
    localparam int CNT_W = $clog2(KEY_W + 1);
    localparam int SW    = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {LOAD, READY, SETTLE, RESP} state_t;

    state_t           state;
    logic [KEY_W-1:0] shadow;
    logic [CNT_W-1:0] cnt;
    logic [SW-1:0]    settle;

`ifdef KEY_PARITY_EN
    logic err_q;
    assign key_err = err_q;
`else
    assign key_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            ckt_in     <= '0;
            ckt_key    <= '0;
            resp_data  <= '0;
            shadow     <= '0;
            cnt        <= '0;
            settle     <= '0;
            query_cnt  <= '0;
            key_loaded <= 1'b0;
            pat_ready  <= 1'b0;
            resp_valid <= 1'b0;
`ifdef KEY_PARITY_EN
            err_q      <= 1'b0;
`endif
        end else if (key_clear) begin
            // zeroize the key and drop any in-flight query without counting it
            state      <= LOAD;
            ckt_in     <= '0;
            ckt_key    <= '0;
            shadow     <= '0;
            cnt        <= '0;
            key_loaded <= 1'b0;
            pat_ready  <= 1'b0;
            resp_valid <= 1'b0;
`ifdef KEY_PARITY_EN
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                LOAD: if (key_svalid) begin
`ifdef KEY_PARITY_EN
                    if (cnt == CNT_W'(KEY_W)) begin
                        cnt <= '0;
                        if (^{key_sdata, shadow}) begin
                            shadow <= '0;
                            err_q  <= 1'b1;
                        end else begin
                            ckt_key    <= shadow;
                            key_loaded <= 1'b1;
                            pat_ready  <= 1'b1;
                            state      <= READY;
                        end
                    end else begin
                        shadow <= {key_sdata, shadow[KEY_W-1:1]};
                        cnt    <= cnt + 1'b1;
                    end
`else
                    shadow <= {key_sdata, shadow[KEY_W-1:1]};
                    if (cnt == CNT_W'(KEY_W - 1)) begin
                        cnt        <= '0;
                        ckt_key    <= {key_sdata, shadow[KEY_W-1:1]};
                        key_loaded <= 1'b1;
                        pat_ready  <= 1'b1;
                        state      <= READY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                READY: if (pat_valid) begin
                    ckt_in    <= pat_data;
                    settle    <= SW'(SETTLE_CYC - 1);
                    pat_ready <= 1'b0;
                    state     <= SETTLE;
                end
                SETTLE: if (settle == '0) begin
                    resp_data  <= ckt_out;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end else begin
                    settle <= settle - 1'b1;
                end
                RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    pat_ready  <= 1'b1;
                    state      <= READY;
                    if (query_cnt != 16'hFFFF) query_cnt <= query_cnt + 1'b1;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_locked_ckt_query_ctrl.sv
// tb_locked_ckt_query_ctrl: directed + randomized checks of locked_ckt_query_ctrl against a transaction-level model.
module tb_locked_ckt_query_ctrl;
    localparam int NI = 32;
    localparam int NO = 32;
    localparam int KW = 16;
    localparam int SC = 2;
`ifdef KEY_PARITY_EN
    localparam int LB = KW + 1;
`else
    localparam int LB = KW;
`endif

    logic          clk = 0, rst = 1, key_sdata = 0, key_svalid = 0, key_clear = 0;
    logic          pat_valid = 0, resp_ready = 0;
    logic [NI-1:0] pat_data = '0;
    logic          key_loaded, pat_ready, resp_valid, key_err;
    logic [NI-1:0] ckt_in;
    logic [KW-1:0] ckt_key;
    logic [NO-1:0] ckt_out, resp_data;
    logic [15:0]   query_cnt;

    locked_ckt_query_ctrl #(.NUM_IN(NI), .NUM_OUT(NO), .KEY_W(KW), .SETTLE_CYC(SC)) dut (
        .clk(clk), .rst(rst), .key_sdata(key_sdata), .key_svalid(key_svalid), .key_clear(key_clear),
        .key_loaded(key_loaded), .pat_data(pat_data), .pat_valid(pat_valid), .pat_ready(pat_ready),
        .ckt_in(ckt_in), .ckt_key(ckt_key), .ckt_out(ckt_out), .resp_data(resp_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .query_cnt(query_cnt), .key_err(key_err)
    );

    // stand-in for the locked netlist
    assign ckt_out = ~ckt_in;

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0=awaiting key, 1=idle, 2=query in flight, 3=response held
    int          m_phase, m_age;
    int unsigned m_cnt;
    bit          m_loaded, m_err;
    logic [KW-1:0] m_key;
    logic [NI-1:0] m_in;
    logic [NO-1:0] m_resp;
    bit          m_bits[$];

    always @(posedge clk) begin
        if (rst || key_clear) begin
            m_phase = 0; m_loaded = 0; m_err = 0; m_key = '0; m_in = '0; m_bits.delete();
            if (rst) begin m_cnt = 0; m_resp = '0; end
        end else begin
            case (m_phase)
                0: if (key_svalid) begin
                    m_bits.push_back(key_sdata);
                    if (m_bits.size() == LB) begin
                        bit par;
                        bit ok;
                        logic [KW-1:0] tk;
                        par = 0;
                        for (int i = 0; i < LB; i++) par ^= m_bits[i];
                        for (int i = 0; i < KW; i++) tk[i] = m_bits[i];
`ifdef KEY_PARITY_EN
                        ok = (par == 0);
`else
                        ok = 1;
`endif
                        if (ok) begin m_key = tk; m_loaded = 1; m_phase = 1; end
                        else m_err = 1;
                        m_bits.delete();
                    end
                end
                1: if (pat_valid) begin m_in = pat_data; m_age = 0; m_phase = 2; end
                2: begin
                    m_age++;
                    if (m_age == SC) begin m_resp = ~m_in; m_phase = 3; end
                end
                default: if (resp_ready) begin
                    if (m_cnt < 32'hFFFF) m_cnt++;
                    m_phase = 1;
                end
            endcase
        end
    end

    always @(negedge clk) if (chk_en) begin
        check("key_loaded", key_loaded, m_loaded);
        check("pat_ready", pat_ready, m_phase == 1);
        check("resp_valid", resp_valid, m_phase == 3);
        check("ckt_key", ckt_key, m_key);
        check("ckt_in", ckt_in, m_in);
        check("resp_data", resp_data, m_resp);
        check("query_cnt", query_cnt, m_cnt);
        check("key_err", key_err, m_err);
    end

    task automatic send_bits(input logic [KW:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            key_svalid = 1;
            key_sdata  = v[i];
        end
        @(negedge clk);
        key_svalid = 0;
    endtask

    task automatic load_key(input logic [KW-1:0] k);
`ifdef KEY_PARITY_EN
        send_bits({^k, k}, KW + 1);
`else
        send_bits({1'b0, k}, KW);
`endif
    endtask

    task automatic do_query(input logic [NI-1:0] p);
        int k = 0;
        pat_valid = 1;
        pat_data  = p;
        @(negedge clk);
        pat_valid = 0;
        while (!resp_valid && k < 20) begin @(negedge clk); k++; end
        check("query_done", k < 20, 1);
        repeat ($urandom_range(2)) @(negedge clk);
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [KW-1:0] k1, k2;
        int k;
        @(negedge clk);
        chk_en = 1;
        check("rst_key_loaded", key_loaded, 0);
        check("rst_pat_ready", pat_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_ckt_key", ckt_key, 0);
        check("rst_query_cnt", query_cnt, 0);
        rst = 0;

        load_key(16'hA5C3);
        check("t1_ckt_key", ckt_key, 16'hA5C3);
        check("t1_key_loaded", key_loaded, 1);
        check("t1_pat_ready", pat_ready, 1);

        pat_valid = 1;
        pat_data  = 32'h0000_FFFF;
        k = 0;
        do begin
            @(negedge clk);
            pat_valid = 0;
            k++;
        end while (!resp_valid && k < 20);
        check("t2_latency", k, 3);
        check("t2_resp_data", resp_data, 32'hFFFF_0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_hold_valid", resp_valid, 1);
            check("t2_hold_data", resp_data, 32'hFFFF_0000);
        end
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
        check("t2_query_cnt", query_cnt, 1);
        check("t2_pat_ready", pat_ready, 1);
        check("t2_resp_valid", resp_valid, 0);

        pat_valid = 1;
        pat_data  = $urandom;
        @(negedge clk);
        key_clear = 1;
        @(negedge clk);
        key_clear = 0;
        pat_valid = 0;
        check("t3_ckt_key", ckt_key, 0);
        check("t3_pat_ready", pat_ready, 0);
        check("t3_key_loaded", key_loaded, 0);
        check("t3_query_cnt", query_cnt, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_no_resp", resp_valid, 0);
        end

        k1 = 16'($urandom);
        load_key(k1);
        for (int i = 0; i < 4; i++) begin
            key_svalid = 1;
            key_sdata  = 1'($urandom);
            @(negedge clk);
        end
        key_svalid = 0;
        check("t4_key_kept", ckt_key, k1);
        key_clear = 1;
        @(negedge clk);
        key_clear = 0;
        for (int i = 0; i < 8; i++) begin
            key_svalid = 1;
            key_sdata  = 1'($urandom);
            @(negedge clk);
        end
        key_svalid = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("t4_rst_ckt_key", ckt_key, 0);
        check("t4_rst_ckt_in", ckt_in, 0);
        check("t4_rst_resp_data", resp_data, 0);
        check("t4_rst_query_cnt", query_cnt, 0);
        check("t4_rst_key_loaded", key_loaded, 0);
        k2 = 16'($urandom);
        load_key(k2);
        check("t4_fresh_key", ckt_key, k2);
        check("t4_fresh_loaded", key_loaded, 1);

        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(499) == 0);
            key_clear  = ($urandom_range(59) == 0);
            key_svalid = 1'($urandom);
            key_sdata  = 1'($urandom);
            pat_valid  = ($urandom_range(2) != 0);
            pat_data   = $urandom;
            resp_ready = 1'($urandom);
            @(negedge clk);
        end
        rst = 1; key_clear = 0; key_svalid = 0; pat_valid = 0; resp_ready = 0;
        @(negedge clk);
        rst = 0;

        load_key(16'h3C5A);
        #1;
        force dut.query_cnt = 16'hFFFE;
        m_cnt = 32'hFFFE;
        @(posedge clk);
        #1;
        release dut.query_cnt;
        @(negedge clk);
        for (int i = 0; i < 3; i++) do_query($urandom);
        check("t5_saturated", query_cnt, 16'hFFFF);

`ifdef KEY_PARITY_EN
        key_clear = 1;
        @(negedge clk);
        key_clear = 0;
        send_bits({1'b0, 16'h0001}, KW + 1);
        check("t6_err_set", key_err, 1);
        check("t6_not_loaded", key_loaded, 0);
        key_clear = 1;
        @(negedge clk);
        key_clear = 0;
        check("t6_err_cleared", key_err, 0);
        send_bits({1'b1, 16'h0001}, KW + 1);
        check("t6_loaded", key_loaded, 1);
        check("t6_ckt_key", ckt_key, 16'h0001);
        check("t6_no_err", key_err, 0);
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
